// File: rtl/spi_log_serializer.sv
// spi_log_serializer
// Buffers flash-read log records ({addr, len}) in a small FIFO and emits them
// as a byte stream to a serial sink. Each byte is followed by one gap cycle,
// and emission pauses while inhibit is high. Records that arrive while the
// FIFO is full are counted. The lost count is reported in-band as a drop
// record (FF FF FF n), which is inserted only between records.
//
// Ports:
//   clk             - single clock
//   reset           - synchronous, active-high
//   log_strobe      - one-cycle pulse with a new record on log_addr/log_len
//   log_addr        - 24-bit flash address of the logged read
//   log_len         - 8-bit byte count of the logged read
//   inhibit         - while high, no byte is emitted
//   uart_txd_ready  - sink can accept a byte
//   uart_txd        - byte to the sink (holds last value when strobe is low)
//   uart_txd_strobe - one-cycle pulse, uart_txd valid
//   dropped         - records lost to overflow since reset, saturating
//   level           - current FIFO occupancy (0..DEPTH)
module spi_log_serializer #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned VERBOSE = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     log_strobe,
    input  logic [23:0]              log_addr,
    input  logic [7:0]               log_len,
    input  logic                     inhibit,
    input  logic                     uart_txd_ready,
    output logic [7:0]               uart_txd,
    output logic                     uart_txd_strobe,
    output logic [15:0]              dropped,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullLevel = DEPTH[AW:0];

    typedef enum logic [1:0] {StIdle, StLoad, StSend, StGap} state_t;

    state_t        state_q, state_d;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    drop_pending_q, drop_pending_d;
    logic [15:0]   dropped_q, dropped_d;
    logic [63:0]   shift_q, shift_d;
    logic [3:0]    byte_cnt_q, byte_cnt_d;
    logic [7:0]    last_q, last_d;

    logic full, empty, push, pop, drop, load_drop, strobe;
    logic [31:0] rd_data;

    assign full    = (count_q == FullLevel);
    assign empty   = (count_q == '0);
    assign rd_data = mem[rd_ptr_q];

    // A drop record takes priority over stored data; it is only ever formed
    // in LOAD, i.e. between records.
    assign load_drop = (state_q == StLoad) && (drop_pending_q != 8'd0);
    assign pop       = (state_q == StLoad) && (drop_pending_q == 8'd0) && !empty;
    // Fullness is judged before the pop, but a same-cycle pop frees a slot.
    assign push      = log_strobe && (!full || pop);
    assign drop      = log_strobe && full && !pop;

    // FIFO bookkeeping and drop counters
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        dropped_d      = dropped_q;
        drop_pending_d = drop_pending_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (drop && dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;

        // Clearing on a drop-record load still counts a drop seen that cycle.
        if (load_drop) begin
            drop_pending_d = drop ? 8'd1 : 8'd0;
        end else if (drop && drop_pending_q != 8'hFF) begin
            drop_pending_d = drop_pending_q + 8'd1;
        end
    end

    // Emission FSM
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        last_d     = last_q;
        strobe     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (drop_pending_q != 8'd0 || !empty) state_d = StLoad;
            end
            StLoad: begin
                state_d = StSend;
                if (load_drop) begin
                    shift_d    = {24'hFF_FFFF, drop_pending_q, 32'h0};
                    byte_cnt_d = 4'd4;
                end else if (!empty) begin
                    if (VERBOSE != 0) begin
                        shift_d    = {32'h5245_4144, rd_data};
                        byte_cnt_d = 4'd8;
                    end else begin
                        shift_d    = {rd_data, 32'h0};
                        byte_cnt_d = 4'd4;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StSend: begin
                if (uart_txd_ready && !inhibit) begin
                    strobe     = 1'b1;
                    last_d     = shift_q[63:56];
                    shift_d    = {shift_q[55:0], 8'h00};
                    byte_cnt_d = byte_cnt_q - 4'd1;
                    state_d    = StGap;
                end
            end
            StGap: begin
                state_d = (byte_cnt_q != 4'd0) ? StSend : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            dropped_q      <= '0;
            drop_pending_q <= '0;
            shift_q        <= '0;
            byte_cnt_q     <= '0;
            last_q         <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            dropped_q      <= dropped_d;
            drop_pending_q <= drop_pending_d;
            shift_q        <= shift_d;
            byte_cnt_q     <= byte_cnt_d;
            last_q         <= last_d;
        end
    end

    // Storage array carries no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {log_addr, log_len};
    end

    // Strobe is combinational so the byte leaves in the SEND cycle itself.
    assign uart_txd_strobe = strobe;
    assign uart_txd        = strobe ? shift_q[63:56] : last_q;
    assign dropped         = dropped_q;
    assign level           = count_q;

endmodule
